// File: rtl/parametrik_verici_decoder.sv
// parametrik_verici_decoder: parallel/serial Gray symbol decoder with optional symbol reversal
module parametrik_verici_decoder #(
    parameter int N = 12,
    parameter int K = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         basla,
    input  logic         mod1,
    input  logic         mod2,
    input  logic         ters,
    input  logic [N-1:0] gelen_veri,
    output logic [N-1:0] cikan_veri,
    output logic         cikan_gecerli,
    output logic         bitti,
    output logic         mesgul,
    output logic         hata
);
    localparam int S = N / K;
    localparam int CW = $clog2(S + 1);
    localparam logic [CW-1:0] SL = CW'(S);
    localparam logic [CW-1:0] SM = CW'(S - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DECODE, OUT, DONE} state_t;

    state_t state, state_n;
    logic m1, m2, tr, m1_n, m2_n, tr_n;
    logic [N-1:0] data, data_n, veri_n, res;
    logic [CW-1:0] cnt, cnt_n;
    logic gec_n, bitti_n, hata_n;
    logic [K-1:0] cur_sym, first_sym;

    function automatic logic [N-1:0] decode(input logic [N-1:0] d, input logic r);
        logic [N-1:0] o;
        logic [K-1:0] g, b;
        o = '0;
        for (int i = 0; i < S; i++) begin
            g = K'(d >> (K * (r ? i : S - 1 - i)));
            b[K-1] = g[K-1];
            for (int j = K - 2; j >= 0; j--) b[j] = b[j+1] ^ g[j];
            o = (o << K) | N'(b);
        end
        return o;
    endfunction

    assign res = decode(data, tr);
    assign first_sym = K'(res >> (K * (S - 1)));
    assign cur_sym = K'(res >> (K * (S - 1 - int'(cnt))));
    assign mesgul = state inside {LOAD, DECODE, OUT};

    always_comb begin
        state_n = state;
        m1_n = m1;
        m2_n = m2;
        tr_n = tr;
        data_n = data;
        cnt_n = cnt;
        veri_n = cikan_veri;
        gec_n = cikan_gecerli;
        bitti_n = bitti;
        hata_n = hata;
        case (state)
            IDLE, DONE: begin
                gec_n = 1'b0;
                if (basla) begin
                    m1_n = mod1;
                    m2_n = mod2;
                    tr_n = ters;
                    bitti_n = 1'b0;
                    hata_n = 1'b0;
                    cnt_n = CW'(1);
                    data_n = mod1 ? N'(gelen_veri[K-1:0]) : gelen_veri;
                    state_n = (mod1 && S > 1) ? LOAD : DECODE;
                end
            end
            LOAD: begin
                if (basla) begin
                    data_n = (data << K) | N'(gelen_veri[K-1:0]);
                    cnt_n = cnt + CW'(1);
                    state_n = (cnt == SM) ? DECODE : LOAD;
                end else begin
                    hata_n = 1'b1;
                    state_n = IDLE;
                end
            end
            DECODE: begin
                veri_n = m2 ? N'(first_sym) : res;
                gec_n = m2;
                bitti_n = m2 ? (S == 1) : 1'b1;
                cnt_n = CW'(1);
                state_n = m2 ? OUT : DONE;
            end
            OUT: begin
                // cnt == S means the last symbol already went out on the previous edge
                if (cnt == SL) begin
                    gec_n = 1'b0;
                    state_n = DONE;
                end else begin
                    veri_n = N'(cur_sym);
                    bitti_n = (cnt == SM);
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            m1 <= 1'b0;
            m2 <= 1'b0;
            tr <= 1'b0;
            data <= '0;
            cnt <= '0;
            cikan_veri <= '0;
            cikan_gecerli <= 1'b0;
            bitti <= 1'b0;
            hata <= 1'b0;
        end else begin
            state <= state_n;
            m1 <= m1_n;
            m2 <= m2_n;
            tr <= tr_n;
            data <= data_n;
            cnt <= cnt_n;
            cikan_veri <= veri_n;
            cikan_gecerli <= gec_n;
            bitti <= bitti_n;
            hata <= hata_n;
        end
    end
endmodule

// File: tb/tb_parametrik_verici_decoder.sv
// tb_parametrik_verici_decoder: randomized self-checking bench against a cycle-timeline model
module tb_parametrik_verici_decoder;
    localparam int N = 12;
    localparam int K = 3;
    localparam int S = N / K;
    localparam logic [N-1:0] MASK = N'((1 << K) - 1);

    logic clk, rst, basla, mod1, mod2, ters;
    logic [N-1:0] gelen_veri, cikan_veri;
    logic cikan_gecerli, bitti, mesgul, hata;

    logic [N-1:0] exp_veri;
    logic exp_gec, exp_bitti, exp_mes, exp_hata, chk_en;
    int n_chk, n_fail;

    parametrik_verici_decoder #(.N(N), .K(K)) dut (
        .clk(clk), .rst(rst), .basla(basla), .mod1(mod1), .mod2(mod2), .ters(ters),
        .gelen_veri(gelen_veri), .cikan_veri(cikan_veri), .cikan_gecerli(cikan_gecerli),
        .bitti(bitti), .mesgul(mesgul), .hata(hata)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string nm, input logic [N-1:0] act, input logic [N-1:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, req);
        end
    endtask

    // Gray to binary as the XOR of all right shifts of the code
    function automatic logic [N-1:0] model(input logic [N-1:0] w, input bit r);
        logic [N-1:0] o;
        int g[S];
        o = '0;
        for (int i = 0; i < S; i++) g[i] = int'((w >> (K * (S - 1 - i))) & MASK);
        for (int i = 0; i < S; i++) begin
            int b, x;
            b = 0;
            x = g[r ? S - 1 - i : i];
            for (int s = 0; s < K; s++) b = b ^ (x >> s);
            o = (o << K) | (N'(b) & MASK);
        end
        return o;
    endfunction

    function automatic logic [N-1:0] sym(input logic [N-1:0] w, input int i);
        return (w >> (K * (S - 1 - i))) & MASK;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("cikan_veri", cikan_veri, exp_veri);
            cmp("cikan_gecerli", N'(cikan_gecerli), N'(exp_gec));
            cmp("bitti", N'(bitti), N'(exp_bitti));
            cmp("mesgul", N'(mesgul), N'(exp_mes));
            cmp("hata", N'(hata), N'(exp_hata));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        mod1 = 1'($urandom);
        mod2 = 1'($urandom);
        ters = 1'($urandom);
        gelen_veri = N'($urandom);
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        exp_veri = '0;
        exp_gec = 0;
        exp_bitti = 0;
        exp_mes = 0;
        exp_hata = 0;
        rst = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            scramble();
            basla = 0;
            tick();
        end
    endtask

    // Drives one transfer from IDLE/DONE; abort_at / rst_at < 0 disable those events
    task automatic txn(input bit i1, input bit i2, input bit it, input logic [N-1:0] w,
                       input int abort_at, input int rst_at);
        logic [N-1:0] r;
        r = model(w, it);
        basla = 1;
        mod1 = i1;
        mod2 = i2;
        ters = it;
        gelen_veri = i1 ? ((N'($urandom) & ~MASK) | sym(w, 0)) : w;
        tick();
        exp_bitti = 0;
        exp_hata = 0;
        exp_gec = 0;
        exp_mes = 1;
        if (i1) begin
            for (int i = 1; i < S; i++) begin
                scramble();
                if (i == abort_at) begin
                    basla = 0;
                    tick();
                    exp_hata = 1;
                    exp_mes = 0;
                    return;
                end
                basla = 1;
                gelen_veri = (N'($urandom) & ~MASK) | sym(w, i);
                tick();
            end
        end
        scramble();
        basla = 1'($urandom);
        tick();
        if (!i2) begin
            exp_veri = r;
            exp_bitti = 1;
            exp_mes = 0;
        end else begin
            exp_veri = sym(r, 0);
            exp_gec = 1;
            for (int i = 1; i < S; i++) begin
                if (i == rst_at) begin
                    do_reset();
                    basla = 0;
                    return;
                end
                scramble();
                basla = 1'($urandom);
                tick();
                exp_veri = sym(r, i);
                exp_bitti = (i == S - 1);
            end
            scramble();
            basla = 1'($urandom);
            tick();
            exp_gec = 0;
            exp_mes = 0;
        end
        basla = 0;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        chk_en = 0;
        basla = 0;
        mod1 = 0;
        mod2 = 0;
        ters = 0;
        gelen_veri = '0;
        cmp("model_pp", model(12'b011_100_010_110, 0), 12'b010_111_011_100);
        cmp("model_rev", model(12'b011_100_010_110, 1), 12'b100_011_111_010);
        cmp("model_so", model(12'b101_011_001_101, 0), 12'b110_010_001_110);
        cmp("model_low", model(12'b000_000_000_111, 0), 12'b000_000_000_101);
        do_reset();
        chk_en = 1;
        do_reset();
        idle(2);

        txn(0, 0, 0, 12'b011_100_010_110, -1, -1);
        cmp("pp_result", cikan_veri, 12'b010_111_011_100);
        idle(2);
        txn(1, 0, 1, 12'b011_100_010_110, -1, -1);
        cmp("sp_rev_result", cikan_veri, 12'b100_011_111_010);
        idle(1);
        txn(0, 1, 0, 12'b101_011_001_101, -1, -1);
        cmp("ps_last_sym", cikan_veri, 12'b000_000_000_110);
        idle(2);
        txn(1, 0, 0, 12'b011_100_010_110, 2, -1);
        cmp("abort_hata", N'(hata), N'(1));
        cmp("abort_bitti", N'(bitti), N'(0));
        idle(3);
        txn(0, 0, 0, 12'b001_010_011_100, -1, -1);
        cmp("after_abort_hata", N'(hata), N'(0));
        txn(0, 1, 0, 12'b110_101_100_011, -1, 2);
        cmp("rst_veri", cikan_veri, 12'b0);
        txn(0, 0, 0, 12'b000_000_000_111, -1, -1);
        cmp("rst_restart", cikan_veri, 12'b000_000_000_101);
        txn(0, 0, 0, 12'b111_111_111_111, -1, -1);
        cmp("b2b_result", cikan_veri, 12'b101_101_101_101);
        idle(1);

        for (int t = 0; t < 80; t++) begin
            bit a, b, c;
            int ab, ra;
            a = 1'($urandom);
            b = 1'($urandom);
            c = 1'($urandom);
            ab = (a && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, S - 1)) : -1;
            ra = (b && ab < 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, S - 1)) : -1;
            txn(a, b, c, N'($urandom), ab, ra);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(2);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
